// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache: one 32-bit word per line.
// A hit returns data in the request cycle; a miss fetches one word from
// mem_ctrl, refills the line and bypasses the word to IF on the done cycle.
module icache_direct #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  input  logic        flush_i,
  input  logic        req_i,
  input  logic [31:0] pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_inst_i,
  input  logic        mem_done_i
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic {IDLE, MISS} state_t;

  state_t                state, state_nxt;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tag_mem  [LINES];
  logic [31:0]           data_mem [LINES];

  // Word address of the outstanding fetch (byte offset is always zero).
  logic [29:0]           miss_word, miss_word_nxt;

  logic [INDEX_BITS-1:0] idx, miss_idx;
  logic [TAG_BITS-1:0]   pc_tag, miss_tag;
  logic                  hit;
  logic                  refill;
  logic                  unused_pc_bits;

  assign idx      = pc_i[INDEX_BITS+1:2];
  assign pc_tag   = pc_i[31:2+INDEX_BITS];
  assign miss_idx = miss_word[INDEX_BITS-1:0];
  assign miss_tag = miss_word[29:INDEX_BITS];
  assign hit      = req_i & valid[idx] & (tag_mem[idx] == pc_tag);

  // Byte offset within the word never affects a fetch.
  assign unused_pc_bits = ^pc_i[1:0];

  // Next-state and output decode; outputs stay purely combinational.
  always_comb begin
    state_nxt     = state;
    miss_word_nxt = miss_word;
    inst_valid_o  = 1'b0;
    inst_o        = 32'h0;
    mem_req_o     = 1'b0;
    mem_addr_o    = 32'h0;
    refill        = 1'b0;
    case (state)
      IDLE: begin
        if (hit) begin
          inst_valid_o = 1'b1;
          inst_o       = data_mem[idx];
        end else if (req_i) begin
          state_nxt     = MISS;
          miss_word_nxt = pc_i[31:2];
        end
      end
      MISS: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {miss_word, 2'b00};
        if (mem_done_i) begin
          refill    = 1'b1;
          state_nxt = IDLE;
          // Forward the returning word only if IF still wants that address.
          if (req_i && (pc_i[31:2] == miss_word)) begin
            inst_valid_o = 1'b1;
            inst_o       = mem_inst_i;
          end
        end
      end
    endcase
  end

  // Control state: FSM, miss address and valid bits; flush beats refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      miss_word <= 30'h0;
      valid     <= '0;
    end else if (rdy_in) begin
      state     <= state_nxt;
      miss_word <= miss_word_nxt;
      if (flush_i)
        valid <= '0;
      else if (refill)
        valid[miss_idx] <= 1'b1;
    end
  end

  // Tag and data arrays are written on refill only and are never reset.
  always_ff @(posedge clk) begin
    if (rdy_in && refill) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= mem_inst_i;
    end
  end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table, async-reset sequence and
// randomized traffic checked against an address-level cache model.
module tb_icache_direct;

  localparam int LINES = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_i = 1'b0;
  logic        req_i = 1'b0;
  logic [31:0] pc_i = 32'h0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_inst_i = 32'h0;
  logic        mem_done_i = 1'b0;

  icache_direct #(.INDEX_BITS(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .rdy_in       (rdy_in),
    .flush_i      (flush_i),
    .req_i        (req_i),
    .pc_i         (pc_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_inst_i   (mem_inst_i),
    .mem_done_i   (mem_done_i)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        flush;
    logic        rdy;
    logic        done;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic        exp_mreq;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[$];

  // Contents of instruction memory as served by the mem_ctrl stand-in.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h01000193 + 32'h13;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % LINES);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, settle before sampling.
  task automatic apply(input logic rq, input logic [31:0] pc, input logic fl,
                       input logic rd, input logic dn, input logic [31:0] mi);
    @(negedge clk);
    req_i = rq; pc_i = pc; flush_i = fl; rdy_in = rd;
    mem_done_i = dn; mem_inst_i = mi;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_i = 1'b0; flush_i = 1'b0; rdy_in = 1'b1; mem_done_i = 1'b0;
    rst = 1'b1;
    #2;
    chk("rst_inst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic mk(input logic rq, input logic [31:0] pc, input logic fl,
                    input logic rd, input logic dn, input logic ev,
                    input logic [31:0] ei, input logic emr, input logic [31:0] ea);
    vec_t v;
    v.req = rq; v.pc = pc; v.flush = fl; v.rdy = rd; v.done = dn;
    v.exp_valid = ev; v.exp_inst = ei; v.exp_mreq = emr; v.exp_addr = ea;
    tbl.push_back(v);
  endtask

  // Reference model state: which word address each line holds.
  logic [31:0] cache_line[int];
  bit          busy;
  logic [31:0] pend;
  int          cd;

  initial begin
    do_reset();

    // ---------------- directed vector table ----------------
    // cold miss on 0x0, done four cycles after the request
    mk(1, 32'h000, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h000, 0, 1, 0, 0, 0,                  1, 32'h000);
    mk(1, 32'h000, 0, 1, 0, 0, 0,                  1, 32'h000);
    mk(1, 32'h000, 0, 1, 0, 0, 0,                  1, 32'h000);
    mk(1, 32'h000, 0, 1, 1, 1, 32'h00000013,       1, 32'h000);
    // hit
    mk(1, 32'h000, 0, 1, 0, 1, 32'h00000013,       0, 0);
    // conflict 0x004 / 0x104
    mk(1, 32'h004, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h004, 0, 1, 1, 1, mem_word(32'h004),  1, 32'h004);
    mk(1, 32'h104, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h106, 0, 1, 1, 1, mem_word(32'h104),  1, 32'h104);
    mk(1, 32'h104, 0, 1, 0, 1, mem_word(32'h104),  0, 0);
    mk(1, 32'h004, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h004, 0, 1, 1, 1, mem_word(32'h004),  1, 32'h004);
    // redirect during miss
    mk(1, 32'h010, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h200, 0, 1, 0, 0, 0,                  1, 32'h010);
    mk(1, 32'h200, 0, 1, 1, 0, 0,                  1, 32'h010);
    mk(1, 32'h010, 0, 1, 0, 1, mem_word(32'h010),  0, 0);
    mk(1, 32'h200, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h200, 0, 1, 1, 1, mem_word(32'h200),  1, 32'h200);
    // flush
    mk(1, 32'h020, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h020, 0, 1, 1, 1, mem_word(32'h020),  1, 32'h020);
    mk(1, 32'h020, 0, 1, 0, 1, mem_word(32'h020),  0, 0);
    mk(0, 32'h020, 1, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h020, 0, 1, 0, 0, 0,                  0, 0);
    // flush coinciding with done: bypass given, line stays invalid
    mk(1, 32'h020, 1, 1, 1, 1, mem_word(32'h020),  1, 32'h020);
    mk(1, 32'h020, 0, 1, 0, 0, 0,                  0, 0);
    // rdy_in low for three cycles mid-MISS
    mk(1, 32'h020, 0, 0, 0, 0, 0,                  1, 32'h020);
    mk(1, 32'h020, 0, 0, 0, 0, 0,                  1, 32'h020);
    mk(1, 32'h020, 0, 0, 0, 0, 0,                  1, 32'h020);
    mk(1, 32'h020, 0, 1, 0, 0, 0,                  1, 32'h020);
    mk(1, 32'h020, 0, 1, 1, 1, mem_word(32'h020),  1, 32'h020);
    mk(0, 32'h020, 0, 1, 0, 0, 0,                  0, 0);
    mk(1, 32'h020, 0, 1, 0, 1, mem_word(32'h020),  0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].req, tbl[i].pc, tbl[i].flush, tbl[i].rdy, tbl[i].done,
            tbl[i].done ? mem_word(tbl[i].exp_addr) : 32'hDEADBEEF);
      chk($sformatf("tbl%0d_valid", i), {31'h0, inst_valid_o}, {31'h0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_mem_req", i), {31'h0, mem_req_o}, {31'h0, tbl[i].exp_mreq});
      if (tbl[i].exp_valid)
        chk($sformatf("tbl%0d_inst", i), inst_o, tbl[i].exp_inst);
      if (tbl[i].exp_mreq)
        chk($sformatf("tbl%0d_mem_addr", i), mem_addr_o, tbl[i].exp_addr);
    end

    // ---------------- async reset mid-MISS ----------------
    apply(1, 32'h040, 0, 1, 0, 32'h0);
    apply(1, 32'h040, 0, 1, 1, mem_word(32'h040));
    apply(1, 32'h040, 0, 1, 0, 32'h0);
    chk("ar_fill_hit", {31'h0, inst_valid_o}, 32'h1);
    apply(1, 32'h080, 0, 1, 0, 32'h0);
    apply(1, 32'h080, 0, 1, 0, 32'h0);
    chk("ar_in_miss", {31'h0, mem_req_o}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("ar_mem_req_drop", {31'h0, mem_req_o}, 32'h0);
    chk("ar_mem_addr_zero", mem_addr_o, 32'h0);
    #1 rst = 1'b0;
    apply(1, 32'h040, 0, 1, 0, 32'h0);
    chk("ar_040_miss", {31'h0, inst_valid_o}, 32'h0);
    chk("ar_040_no_req_yet", {31'h0, mem_req_o}, 32'h0);
    apply(1, 32'h040, 0, 1, 1, mem_word(32'h040));
    chk("ar_040_bypass", inst_o, mem_word(32'h040));
    apply(1, 32'h020, 0, 1, 0, 32'h0);
    chk("ar_020_miss", {31'h0, inst_valid_o}, 32'h0);
    apply(1, 32'h020, 0, 1, 1, mem_word(32'h020));

    // ---------------- randomized traffic vs model ----------------
    do_reset();
    cache_line.delete();
    busy = 0;
    pend = 0;
    cd = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rd, fl, rq, dn, ev, in_cache;
      logic [31:0] pc, mi, ei;
      int          ix;
      rd = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 24) == 0);
      rq = ($urandom_range(0, 4) != 0);
      pc = ($urandom_range(0, 1) != 0 ? 32'h80000000 : 32'h0)
         | (32'($urandom_range(0, 3)) << 8)
         | (32'($urandom_range(0, 3)) << 2)
         | 32'($urandom_range(0, 3));
      if (busy && $urandom_range(0, 1) != 0)
        pc = pend | 32'($urandom_range(0, 3));
      dn = busy && rd && (cd == 0);
      mi = dn ? mem_word(pend) : $urandom;
      ix = line_of(pc);
      in_cache = cache_line.exists(ix) && (cache_line[ix] == (pc & ~32'h3));
      if (!busy) begin
        ev = rq && in_cache;
        ei = mem_word(pc & ~32'h3);
      end else begin
        ev = dn && rq && ((pc & ~32'h3) == pend);
        ei = mem_word(pend);
      end
      apply(rq, pc, fl, rd, dn, mi);
      chk("rnd_valid", {31'h0, inst_valid_o}, {31'h0, ev});
      chk("rnd_mem_req", {31'h0, mem_req_o}, {31'h0, busy});
      if (ev) chk("rnd_inst", inst_o, ei);
      if (busy) chk("rnd_mem_addr", mem_addr_o, pend);
      if (rd) begin
        if (busy) begin
          if (dn) begin
            busy = 0;
            cache_line[line_of(pend)] = pend;
          end else begin
            cd--;
          end
        end else if (rq && !in_cache) begin
          busy = 1;
          pend = pc & ~32'h3;
          cd = $urandom_range(0, 3);
        end
        if (fl) cache_line.delete();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
